input_flit_buffer: RTL and testbench

//  Per-input-port flit FIFO of the 4x4 mesh router. Sits directly upstream of direction_analyzer.

---
 rtl/noc_pkg.sv | 67 ++++++
 rtl/input_flit_buffer.sv | 123 ++++++++++++
 tb/tb_input_flit_buffer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared definitions for the 4x4 mesh NoC: flit layout, field positions and
// the router-index to mesh-location table used by the routing stages.
package noc_pkg;

    localparam int FLIT_W       = 17;
    localparam int DEST_COL_LSB = 0;
    localparam int DEST_ROW_LSB = 4;
    localparam int PAYLOAD_LSB  = 8;
    localparam int DEST_W       = 4;
    localparam int PAYLOAD_W    = FLIT_W - PAYLOAD_LSB;
    localparam int MESH_DIM     = 4;
    localparam int NUM_ROUTERS  = MESH_DIM * MESH_DIM;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef struct packed {
        logic [1:0] row;
        logic [1:0] col;
    } mesh_loc_t;

    // Routers are numbered row-major: index = row*4 + col.
    function automatic mesh_loc_t router_loc(input logic [3:0] id);
        mesh_loc_t loc;
        case (id)
            4'd0:    loc = '{row: 2'd0, col: 2'd0};
            4'd1:    loc = '{row: 2'd0, col: 2'd1};
            4'd2:    loc = '{row: 2'd0, col: 2'd2};
            4'd3:    loc = '{row: 2'd0, col: 2'd3};
            4'd4:    loc = '{row: 2'd1, col: 2'd0};
            4'd5:    loc = '{row: 2'd1, col: 2'd1};
            4'd6:    loc = '{row: 2'd1, col: 2'd2};
            4'd7:    loc = '{row: 2'd1, col: 2'd3};
            4'd8:    loc = '{row: 2'd2, col: 2'd0};
            4'd9:    loc = '{row: 2'd2, col: 2'd1};
            4'd10:   loc = '{row: 2'd2, col: 2'd2};
            4'd11:   loc = '{row: 2'd2, col: 2'd3};
            4'd12:   loc = '{row: 2'd3, col: 2'd0};
            4'd13:   loc = '{row: 2'd3, col: 2'd1};
            4'd14:   loc = '{row: 2'd3, col: 2'd2};
            4'd15:   loc = '{row: 2'd3, col: 2'd3};
            default: loc = '{row: 2'd0, col: 2'd0};
        endcase
        return loc;
    endfunction

    // Destination fields in a flit are one-hot over the four rows/columns.
    function automatic logic [DEST_W-1:0] to_onehot(input logic [1:0] idx);
        logic [DEST_W-1:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    function automatic logic [DEST_W-1:0] flit_dest_row(input flit_t f);
        return f[DEST_ROW_LSB +: DEST_W];
    endfunction

    function automatic logic [DEST_W-1:0] flit_dest_col(input flit_t f);
        return f[DEST_COL_LSB +: DEST_W];
    endfunction

endpackage

// File: rtl/input_flit_buffer.sv
// Per-input-port first-word-fall-through flit FIFO feeding direction_analyzer.
// Head flit is visible one cycle after it is written; removal on allocator pop.
module input_flit_buffer
    import noc_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ROUTER_ID = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     valid_i,
    input  flit_t                    data_i,
    output logic                     ready_o,
    output logic                     valid_o,
    output flit_t                    data_o,
    input  logic                     pop_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);

    // Reject bad elaboration-time parameters; ROUTER_ID is otherwise only a debug tag.
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (ROUTER_ID < 0) || (ROUTER_ID >= NUM_ROUTERS)) begin : g_bad_param
        $error("input_flit_buffer: DEPTH must be a power of two >= 2 and ROUTER_ID in 0..15");
    end

    flit_t            mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             err_r;

    logic [PTR_W-1:0] wr_ptr_nxt_s;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic             err_nxt_s;
    logic             empty_s;
    logic             full_s;
    logic             push_s;
    logic             pop_s;

    // Occupancy status and handshake qualification, from registered count only.
    always_comb begin
        empty_s = (count_r == {CNT_W{1'b0}});
        full_s  = (count_r == FULL_CNT);
        push_s  = valid_i & ~full_s;
        pop_s   = pop_i & ~empty_s;
    end

    // Next-state for pointers, occupancy and the sticky underflow flag.
    always_comb begin
        wr_ptr_nxt_s = wr_ptr_r;
        rd_ptr_nxt_s = rd_ptr_r;
        count_nxt_s  = count_r;
        err_nxt_s    = err_r;

        if (push_s) begin
            wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
        end else begin
            wr_ptr_nxt_s = wr_ptr_r;
        end

        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end

        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase

        if (pop_i && empty_s) begin
            err_nxt_s = 1'b1;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // Control state registers; stored flits are discarded by clearing count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            wr_ptr_r <= wr_ptr_nxt_s;
            rd_ptr_r <= rd_ptr_nxt_s;
            count_r  <= count_nxt_s;
            err_r    <= err_nxt_s;
        end
    end

    // Flit storage; deliberately not reset so it maps onto plain RAM/regfile.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Head flit is masked to zero when empty so stale slots never leak downstream.
    always_comb begin
        if (!empty_s) begin
            data_o = mem_r[rd_ptr_r];
        end else begin
            data_o = {FLIT_W{1'b0}};
        end
    end

    assign valid_o = ~empty_s;
    assign ready_o = ~full_s;
    assign count_o = count_r;
    assign err_o   = err_r;

endmodule

// File: tb/tb_input_flit_buffer.sv
// Self-checking bench for input_flit_buffer: vector table plus queue scoreboard,
// with hand sequences for streaming, underflow and asynchronous reset.
module tb_input_flit_buffer;
    import noc_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    flit_t       data_i;
    logic        ready_o;
    logic        valid_o;
    flit_t       data_o;
    logic        pop_i;
    logic [2:0]  count_o;
    logic        err_o;

    int errors = 0;
    int checks = 0;

    flit_t sb_q[$];
    logic  m_err = 1'b0;

    typedef struct {
        logic       v;
        flit_t      d;
        logic       p;
        logic [2:0] c;
        logic       vo;
        logic       ro;
    } vec_t;

    vec_t tbl[$];

    input_flit_buffer #(.DEPTH(DEPTH), .ROUTER_ID(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .data_o  (data_o),
        .pop_i   (pop_i),
        .count_o (count_o),
        .err_o   (err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare every output against the scoreboard model.
    task automatic check_state(input string tag);
        int    n;
        flit_t head;
        n = sb_q.size();
        head = (n != 0) ? sb_q[0] : 17'h00000;
        chk({tag, ".count"}, 32'(count_o), 32'(n));
        chk({tag, ".valid"}, 32'(valid_o), 32'(n != 0));
        chk({tag, ".ready"}, 32'(ready_o), 32'(n != DEPTH));
        chk({tag, ".err"},   32'(err_o),   32'(m_err));
        chk({tag, ".data"},  32'(data_o),  32'(head));
    endtask

    // Drive one cycle from a negedge; checks that inputs do not reach outputs combinationally.
    task automatic step(input logic v, input flit_t d, input logic p, input string tag);
        int n;
        n = sb_q.size();
        valid_i = v;
        data_i  = d;
        pop_i   = p;
        #1;
        chk({tag, ".comb_valid"}, 32'(valid_o), 32'(n != 0));
        chk({tag, ".comb_ready"}, 32'(ready_o), 32'(n != DEPTH));
        if (p && (n == 0)) m_err = 1'b1;
        if (p && (n != 0)) void'(sb_q.pop_front());
        if (v && (n != DEPTH)) sb_q.push_back(d);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b0;
        pop_i   = 1'b0;
        data_i  = 17'h00000;

        // Test 1: outputs while in reset and after release.
        #1;
        chk("rst.valid", 32'(valid_o), 32'd0);
        chk("rst.ready", 32'(ready_o), 32'd1);
        chk("rst.count", 32'(count_o), 32'd0);
        chk("rst.data",  32'(data_o),  32'd0);
        chk("rst.err",   32'(err_o),   32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 17'h00000, 1'b0, "idle");
        step(1'b0, 17'h00000, 1'b0, "idle");
        check_state("idle");

        // Tests 2, 3, 5: expected count/valid/ready are the state seen before each vector's edge.
        tbl.push_back('{1'b1, 17'h00122, 1'b0, 3'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 17'h00000, 1'b1, 3'd1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 17'h00000, 1'b0, 3'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 17'h0A011, 1'b0, 3'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 17'h0A022, 1'b0, 3'd1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 17'h0A044, 1'b0, 3'd2, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 17'h0A088, 1'b0, 3'd3, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 17'h0A0FF, 1'b0, 3'd4, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 17'h00000, 1'b1, 3'd4, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 17'h00000, 1'b1, 3'd3, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 17'h00000, 1'b1, 3'd2, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 17'h00000, 1'b1, 3'd1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 17'h00000, 1'b0, 3'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 17'h0B011, 1'b0, 3'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 17'h0B022, 1'b0, 3'd1, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 17'h0B044, 1'b0, 3'd2, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 17'h0B088, 1'b0, 3'd3, 1'b1, 1'b1});
        tbl.push_back('{1'b1, 17'h1FFFF, 1'b1, 3'd4, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 17'h0B0F0, 1'b0, 3'd3, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 17'h00000, 1'b0, 3'd4, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 17'h00000, 1'b1, 3'd4, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 17'h00000, 1'b1, 3'd3, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 17'h00000, 1'b1, 3'd2, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 17'h00000, 1'b1, 3'd1, 1'b1, 1'b1});
        tbl.push_back('{1'b0, 17'h00000, 1'b0, 3'd0, 1'b0, 1'b1});

        for (int i = 0; i < tbl.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            chk({tag, ".tcount"}, 32'(count_o), 32'(tbl[i].c));
            chk({tag, ".tvalid"}, 32'(valid_o), 32'(tbl[i].vo));
            chk({tag, ".tready"}, 32'(ready_o), 32'(tbl[i].ro));
            check_state(tag);
            step(tbl[i].v, tbl[i].d, tbl[i].p, tag);
        end
        check_state("table_end");

        // Test 4: streaming at occupancy 2, including malformed destination fields.
        step(1'b1, 17'h0C001, 1'b0, "stream_fill");
        step(1'b1, 17'h000FF, 1'b0, "stream_fill");
        for (int k = 0; k < 10; k++) begin
            flit_t f;
            f = flit_t'(17'h10000 | (k * 17'h00111));
            check_state($sformatf("stream%0d", k));
            chk($sformatf("stream%0d.cnt2", k), 32'(count_o), 32'd2);
            step(1'b1, f, 1'b1, $sformatf("stream%0d", k));
        end
        for (int k = 0; k < 2; k++) begin
            check_state($sformatf("stream_drain%0d", k));
            step(1'b0, 17'h00000, 1'b1, "stream_drain");
        end
        check_state("stream_empty");

        // Test 6: underflow sets a sticky error.
        step(1'b0, 17'h00000, 1'b1, "underflow");
        check_state("underflow");
        chk("underflow.err", 32'(err_o), 32'd1);
        step(1'b1, 17'h0D011, 1'b0, "err_hold");
        step(1'b1, 17'h0D022, 1'b0, "err_hold");
        step(1'b1, 17'h0D044, 1'b0, "err_hold");
        check_state("pre_reset");
        chk("pre_reset.err", 32'(err_o), 32'd1);

        // Asynchronous reset between clock edges.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst.valid", 32'(valid_o), 32'd0);
        chk("async_rst.count", 32'(count_o), 32'd0);
        chk("async_rst.err",   32'(err_o),   32'd0);
        chk("async_rst.ready", 32'(ready_o), 32'd1);
        chk("async_rst.data",  32'(data_o),  32'd0);
        sb_q.delete();
        m_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 17'h0E042, 1'b0, "post_rst");
        check_state("post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
